alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX boundary stage of the RV32I core that produces the ALU's operand and control inputs. It decodes a 32-bit instruction, generates the immediate, and selects operands A and B (register data, PC, immediate, 0 or 4). It maps opcode/funct3/funct7 onto the 4-bit ALU operation code and registers everything into one pipeline slot. Upstream and downstream use a valid/ready handshake; a synchronous flush turns the slot into a bubble.

## Interface
- No parameters; all datapaths are 32 bits.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data, rs2_data  in  32 each  register file read data
- flush  in  1  squash slot (branch redirect)
- out_valid  out  1  registered slot holds an instruction
- out_ready  in  1  execute side consumes slot
- inA, inB  out  32 each  registered ALU operands
- ALUCtrlOut  out  4  registered ALU operation code
- imm_out  out  32  registered immediate (branch/jump target use)
- pc_out  out  32  registered pc
- is_branch  out  1  registered: conditional branch
- br_funct3  out  3  registered instr[14:12] for branches, else 0
- illegal  out  1  registered: unsupported opcode/funct

## Operation
- ALU codes (fixed): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Immediates, sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
- Decode by opcode instr[6:0]:
  - 0110011 R-type: A=rs1, B=rs2. funct3 000 → ADD, or SUB if instr[30]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if instr[30]; 110 OR; 111 AND. instr[31:25] must be 0000000, or 0100000 for 000/101 only; otherwise illegal.
  - 0010011 I-ALU: A=rs1, B=immI. Same funct3 map, except 000 is always ADD. 001 requires instr[31:25]=0. For 101, instr[30] selects SRA; other upper bits must be 0, else illegal.
  - 0000011 load / 0100011 store: A=rs1, B=immI/immS, ADD.
  - 1100011 branch: A=rs1, B=rs2, is_branch=1, imm_out=immB.
    - funct3 000/001 → SUB
    - 100/101 → SLT
    - 110/111 → SLTU
    - 010/011 → illegal
  - 0110111 LUI: A=0, B=immU, ADD.
  - 0010111 AUIPC: A=pc, B=immU, ADD.
  - 1101111 JAL: A=pc, B=4, ADD, imm_out=immJ.
  - 1100111 JALR: A=pc, B=4, ADD, imm_out=immI. funct3≠000 is illegal.
  - Any other opcode: illegal=1, A=B=0, ADD.
- The slot is a single register. A load occurs when in_valid && in_ready && !flush.
- in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid).
- Per cycle, in priority order:
  - flush → out_valid←0
  - load → capture all decoded fields, out_valid←1
  - out_ready && out_valid → out_valid←0
  - else hold all registers.
- Simultaneous consume and load: the new instruction replaces the old one; out_valid stays 1.
- Illegal instructions still flow through with illegal=1; trap handling is downstream.

## Timing
- Reset (async assert, synchronous deassert by the environment): out_valid=0, and all data outputs, is_branch, br_funct3 and illegal are 0.
- Latency: 1 cycle from an accepted in_valid to out_valid. Throughput is 1 instruction/cycle while out_ready=1.
- While out_valid && !out_ready, all outputs are stable and in_ready=0.
- A flush in the same cycle as a handshake drops the incoming instruction. in_ready may read 1 during flush; the instruction is still not captured.
- Reset mid-stream discards the slot immediately. No partial state survives.
- Data outputs after a consume without a reload keep their last values and are don't-care while out_valid=0.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → out_valid, inA, inB and ALUCtrlOut read 0 immediately, before the next clock edge.
- R-type sweep: `sub x3,x1,x2` (0x402081B3) with rs1=5, rs2=7 → next cycle inA=5, inB=7, ALUCtrlOut=1. Then `sra` → 7, `sltu` → 9.
- Immediates: `addi x1,x0,-1` → inB=0xFFFFFFFF, code 0. `lui 0x12345` → inA=0, inB=0x12345000. `auipc` at pc=0x100 → inA=0x100. `jal` → inB=4, imm_out=J-immediate.
- Branches: `blt` → code 8, is_branch=1, br_funct3=100. `bgeu` → code 9. funct3=010 → illegal=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. Then out_ready=1 → consume and reload in the same edge; no instruction lost or duplicated.
- Flush: assert flush with in_valid=1 and out_valid=1 → next cycle out_valid=0 and the offered instruction is not captured.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-side and execute-side handshake plus ALU operand bus of the issue stage
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [3:0]  ALUCtrlOut;
    logic [31:0] imm_out;
    logic [31:0] pc_out;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, inA, inB, ALUCtrlOut, imm_out, pc_out, is_branch, br_funct3, illegal
    );
    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, inA, inB, ALUCtrlOut, imm_out, pc_out, is_branch, br_funct3, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode to ALU operands/opcode, registered into one handshaked pipeline slot
module alu_issue_stage (
    input logic       clk,
    input logic       rst_n,
    alu_issue_if.slave bus
);
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                           SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_map = alt ? SUB : ADD;
            3'b001:  alu_map = SLL;
            3'b010:  alu_map = SLT;
            3'b011:  alu_map = SLTU;
            3'b100:  alu_map = XOR;
            3'b101:  alu_map = alt ? SRA : SRL;
            3'b110:  alu_map = OR;
            default: alu_map = AND;
        endcase
    endfunction

    logic [31:0] ins;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        load;
    logic [31:0] a_d, b_d, imm_d, a_q, b_q, imm_q, pc_q;
    logic [3:0]  alu_d, alu_q;
    logic        br_d, br_q, ill_d, ill_q, valid_q;
    logic [2:0]  f3_d, f3_q;

    assign ins   = bus.instr;
    assign op    = ins[6:0];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

    assign bus.in_ready   = !valid_q || bus.out_ready;
    assign load           = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.out_valid  = valid_q;
    assign bus.inA        = a_q;
    assign bus.inB        = b_q;
    assign bus.ALUCtrlOut = alu_q;
    assign bus.imm_out    = imm_q;
    assign bus.pc_out     = pc_q;
    assign bus.is_branch  = br_q;
    assign bus.br_funct3  = f3_q;
    assign bus.illegal    = ill_q;

    // Decode the offered instruction into operands, ALU code and side-band fields
    always_comb begin
        a_d   = '0;
        b_d   = '0;
        imm_d = '0;
        alu_d = ADD;
        br_d  = 1'b0;
        f3_d  = 3'b0;
        ill_d = 1'b0;
        case (op)
            OP_R: begin
                a_d   = bus.rs1_data;
                b_d   = bus.rs2_data;
                alu_d = alu_map(f3, ins[30]);
                ill_d = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_I: begin
                a_d   = bus.rs1_data;
                b_d   = imm_i;
                imm_d = imm_i;
                alu_d = alu_map(f3, f3 == 3'b101 && ins[30]);
                ill_d = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && {f7[6], f7[4:0]} != 6'b0);
            end
            OP_LD: begin
                a_d   = bus.rs1_data;
                b_d   = imm_i;
                imm_d = imm_i;
            end
            OP_ST: begin
                a_d   = bus.rs1_data;
                b_d   = imm_s;
                imm_d = imm_s;
            end
            OP_BR: begin
                a_d   = bus.rs1_data;
                b_d   = bus.rs2_data;
                imm_d = imm_b;
                br_d  = 1'b1;
                f3_d  = f3;
                alu_d = !f3[2] ? (f3[1] ? ADD : SUB) : (f3[1] ? SLTU : SLT);
                ill_d = f3[2:1] == 2'b01;
            end
            OP_LUI: begin
                b_d   = imm_u;
                imm_d = imm_u;
            end
            OP_AUIPC: begin
                a_d   = bus.pc;
                b_d   = imm_u;
                imm_d = imm_u;
            end
            OP_JAL: begin
                a_d   = bus.pc;
                b_d   = 32'd4;
                imm_d = imm_j;
            end
            OP_JALR: begin
                a_d   = bus.pc;
                b_d   = 32'd4;
                imm_d = imm_i;
                ill_d = f3 != 3'b000;
            end
            default: ill_d = 1'b1;
        endcase
    end

    // Slot register: flush beats load, load beats consume, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            br_q    <= 1'b0;
            f3_q    <= '0;
            ill_q   <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            pc_q    <= bus.pc;
            alu_q   <= alu_d;
            br_q    <= br_d;
            f3_q    <= f3_d;
            ill_q   <= ill_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of the issue stage against a behavioural slot model
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    alu_issue_if bus ();
    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a, b, imm, pc;
        logic [3:0]  alu;
        logic        br;
        logic [2:0]  f3;
        logic        ill, chk_alu, chk_imm;
    } exp_t;

    exp_t m;
    logic mv = 1'b0;

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pcv, r1, r2);
        logic [3:0]  tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        logic [2:0]  f3 = i[14:12];
        logic [6:0]  f7 = i[31:25];
        logic [31:0] ii = 32'($signed(i[31:20]));
        logic [31:0] is = 32'($signed({i[31:25], i[11:7]}));
        logic [31:0] ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        logic [31:0] iu = i[31:12] * 32'd4096;
        logic [31:0] ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        exp_t e = '0;
        e.pc = pcv;
        e.chk_alu = 1'b1;
        if (i[6:0] == 7'h33) begin
            e.a = r1; e.b = r2;
            e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            e.alu = tbl[f3] + 4'(f7 == 7'h20);
        end else if (i[6:0] == 7'h13) begin
            e.a = r1; e.b = ii;
            e.ill = (f3 == 1) ? f7 != 0 : (f3 == 5) ? (f7 & 7'h5f) != 0 : 1'b0;
            e.alu = tbl[f3] + 4'(f3 == 5 && i[30]);
        end else if (i[6:0] == 7'h03) begin
            e.a = r1; e.b = ii;
        end else if (i[6:0] == 7'h23) begin
            e.a = r1; e.b = is;
        end else if (i[6:0] == 7'h63) begin
            e.a = r1; e.b = r2; e.br = 1'b1; e.f3 = f3; e.imm = ib; e.chk_imm = 1'b1;
            e.ill = (f3 == 2 || f3 == 3);
            e.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd8 : 4'd9;
        end else if (i[6:0] == 7'h37) begin
            e.b = iu;
        end else if (i[6:0] == 7'h17) begin
            e.a = pcv; e.b = iu;
        end else if (i[6:0] == 7'h6f) begin
            e.a = pcv; e.b = 4; e.imm = ij; e.chk_imm = 1'b1;
        end else if (i[6:0] == 7'h67) begin
            e.a = pcv; e.b = 4; e.imm = ii; e.chk_imm = 1'b1;
            e.ill = f3 != 0;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill && i[6:0] != 7'h33 && i[6:0] != 7'h13 && i[6:0] != 7'h63 && i[6:0] != 7'h67) e.chk_alu = 1'b1;
        else if (e.ill) e.chk_alu = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_slot();
        chk("out_valid", 32'(bus.out_valid), 32'(mv));
        if (mv) begin
            chk("illegal", 32'(bus.illegal), 32'(m.ill));
            chk("inA", bus.inA, m.a);
            chk("inB", bus.inB, m.b);
            chk("pc_out", bus.pc_out, m.pc);
            if (m.chk_alu) chk("alu", 32'(bus.ALUCtrlOut), 32'(m.alu));
            if (!m.ill) begin
                chk("is_branch", 32'(bus.is_branch), 32'(m.br));
                chk("br_funct3", 32'(bus.br_funct3), 32'(m.f3));
            end
            if (m.chk_imm) chk("imm_out", bus.imm_out, m.imm);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                        input logic [31:0] r1, input logic [31:0] r2, input logic ordy, input logic fl);
        bus.in_valid = v; bus.instr = ins; bus.pc = pcv;
        bus.rs1_data = r1; bus.rs2_data = r2; bus.out_ready = ordy; bus.flush = fl;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!mv || ordy));
        @(posedge clk);
        if (fl) mv = 1'b0;
        else if (v && (!mv || ordy)) begin mv = 1'b1; m = ref_decode(ins, pcv, r1, r2); end
        else if (ordy && mv) mv = 1'b0;
        #1;
        check_slot();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_inA"}, bus.inA, 0);
        chk({tag, "_inB"}, bus.inB, 0);
        chk({tag, "_alu"}, 32'(bus.ALUCtrlOut), 0);
        chk({tag, "_imm"}, bus.imm_out, 0);
        chk({tag, "_pc"}, bus.pc_out, 0);
        chk({tag, "_br"}, 32'({bus.is_branch, bus.br_funct3, bus.illegal}), 0);
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};

    initial begin
        logic [31:0] ri;
        bus.in_valid = 0; bus.instr = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0;
        bus.out_ready = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h402081B3, 32'h0, 5, 7, 1, 0);
        chk("sub_inA", bus.inA, 5);
        chk("sub_inB", bus.inB, 7);
        chk("sub_alu", 32'(bus.ALUCtrlOut), 1);
        step(1, 32'h4020D1B3, 32'h4, 5, 7, 1, 0);
        chk("sra_alu", 32'(bus.ALUCtrlOut), 7);
        step(1, 32'h0020B1B3, 32'h8, 5, 7, 1, 0);
        chk("sltu_alu", 32'(bus.ALUCtrlOut), 9);
        step(1, 32'hFFF00093, 32'hC, 3, 0, 1, 0);
        chk("addi_inB", bus.inB, 32'hFFFFFFFF);
        step(1, 32'h123450B7, 32'h10, 3, 3, 1, 0);
        chk("lui_inA", bus.inA, 0);
        chk("lui_inB", bus.inB, 32'h12345000);
        step(1, 32'h00001097, 32'h100, 3, 3, 1, 0);
        chk("auipc_inA", bus.inA, 32'h100);
        step(1, 32'h008000EF, 32'h104, 3, 3, 1, 0);
        chk("jal_inB", bus.inB, 4);
        chk("jal_imm", bus.imm_out, 8);
        step(1, 32'h0020C863, 32'h108, 1, 2, 1, 0);
        chk("blt", 32'({bus.ALUCtrlOut, bus.is_branch, bus.br_funct3}), 32'({4'd8, 1'b1, 3'b100}));
        chk("blt_imm", bus.imm_out, 16);
        step(1, 32'h0020F863, 32'h10C, 1, 2, 1, 0);
        chk("bgeu_alu", 32'(bus.ALUCtrlOut), 9);
        step(1, 32'h0020A863, 32'h110, 1, 2, 1, 0);
        chk("br010_ill", 32'(bus.illegal), 1);
        step(1, 32'h0000007F, 32'h114, 1, 2, 1, 0);
        step(1, 32'h004100E7, 32'h118, 1, 2, 1, 0);
        // backpressure: three stalled cycles then consume-and-reload
        step(1, 32'h00208133, 32'h200, 11, 22, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 32'h40208133, 32'h204, 33, 44, 0, 0);
        step(1, 32'h40208133, 32'h204, 33, 44, 1, 0);
        chk("bp_reload_inA", bus.inA, 33);
        step(0, 32'h0, 32'h0, 0, 0, 1, 0);
        // flush with an instruction offered and the slot full
        step(1, 32'h00208133, 32'h300, 1, 1, 0, 0);
        step(1, 32'h0020C863, 32'h304, 2, 2, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 1, 0);
        for (int k = 0; k < 300; k++) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 2))
                0: ri[31:25] = 7'h00;
                1: ri[31:25] = 7'h20;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, ri, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        // asynchronous reset in the middle of a cycle with the slot full
        step(1, 32'h402081B3, 32'h400, 9, 1, 1, 0);
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        mv = 1'b0;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h0020B1B3, 32'h500, 4, 6, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
